ad9833_spi_rx: RTL and testbench

- Receive-side model of the AD9833 3-wire serial port: SPI mode 2, 16-bit words, MSB first, data sampled on the falling sclk edge while fsync is low.
- Oversamples fsync/sclk/sdata on the system clock, reassembles each 16-bit word and decodes it into an AD9833 register shadow: CONTROL, FREQ0, FREQ1, PHASE0, PHASE1.
- Sits in the FPGA fabric, either on the same pins driven by the AD9833 transmitter/Avalon wrapper or looped back from them.
- Used as a bus monitor and self-check target. Its shadow registers must always equal what a real AD9833 would hold.

---
 rtl/ad9833_spi_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_ad9833_spi_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9833_spi_rx.sv
// ---------------------------------------------------------------------------
// ad9833_spi_rx
// Receive-side model of the AD9833 3-wire serial port (SPI mode 2, 16-bit
// words, MSB first, data sampled on falling sclk while fsync is low).
// Oversamples the serial lines on the system clock, rebuilds each word and
// keeps a shadow copy of the AD9833 CONTROL/FREQ0/FREQ1/PHASE0/PHASE1 state.
//
// Ports:
//   clock       in   system clock
//   resetn      in   asynchronous reset, active low
//   fsync       in   frame sync, active low (async to clock)
//   sclk        in   serial clock (async to clock)
//   sdata       in   serial data (async to clock)
//   word        out  last complete received word
//   word_valid  out  one-cycle pulse when word updates
//   control     out  CONTROL bits D13..D0
//   freq0/1     out  28-bit frequency registers
//   phase0/1    out  12-bit phase registers
//   frame_error out  one-cycle pulse when fsync rises mid-word
//   busy        out  high while a word is partially shifted in
// ---------------------------------------------------------------------------
module ad9833_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        fsync,
  input  logic        sclk,
  input  logic        sdata,
  output logic [15:0] word,
  output logic        word_valid,
  output logic [13:0] control,
  output logic [27:0] freq0,
  output logic [27:0] freq1,
  output logic [11:0] phase0,
  output logic [11:0] phase1,
  output logic        frame_error,
  output logic        busy
);

  // Synchronizer chains; element [SYNC_STAGES-1] is the synced value.
  logic [SYNC_STAGES-1:0] r_fsync_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_fsync_prev;
  logic                   r_sclk_prev;

  logic [15:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic        r_done;       // full word sits in r_shift, decode next edge
  logic        r_half_msb;   // shared B28 half-select: 0 = LSB, 1 = MSB

  logic [15:0] r_word;
  logic        r_word_valid;
  logic [13:0] r_control;
  logic [27:0] r_freq0;
  logic [27:0] r_freq1;
  logic [11:0] r_phase0;
  logic [11:0] r_phase1;
  logic        r_frame_error;

  logic        w_fsync_s;
  logic        w_sclk_s;
  logic        w_sdata_s;
  logic        w_sclk_fall;
  logic        w_fsync_rise;
  logic        w_shift_en;
  logic        w_busy;

  logic [13:0] w_control_nxt;
  logic [27:0] w_freq0_nxt;
  logic [27:0] w_freq1_nxt;
  logic [11:0] w_phase0_nxt;
  logic [11:0] w_phase1_nxt;
  logic        w_half_msb_nxt;
  logic        w_freq_hi;

  assign w_fsync_s    = r_fsync_sync[SYNC_STAGES-1];
  assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
  assign w_sdata_s    = r_sdata_sync[SYNC_STAGES-1];
  assign w_sclk_fall  = r_sclk_prev & ~w_sclk_s;
  assign w_fsync_rise = ~r_fsync_prev & w_fsync_s;
  assign w_shift_en   = w_sclk_fall & ~w_fsync_s;
  assign w_busy       = (r_bit_cnt != 4'd0);

  // Synchronize the serial lines with equal delay and keep previous values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fsync_sync <= {SYNC_STAGES{1'b1}};
      r_sclk_sync  <= {SYNC_STAGES{1'b1}};
      r_sdata_sync <= {SYNC_STAGES{1'b0}};
      r_fsync_prev <= 1'b1;
      r_sclk_prev  <= 1'b1;
    end else begin
      r_fsync_sync <= {r_fsync_sync[SYNC_STAGES-2:0], fsync};
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata};
      r_fsync_prev <= w_fsync_s;
      r_sclk_prev  <= w_sclk_s;
    end
  end

  // Shift register, bit counter and abort detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shift       <= 16'h0000;
      r_bit_cnt     <= 4'd0;
      r_done        <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      // A rising fsync implies synced fsync is high, so it never coincides
      // with a shift.
      if (w_fsync_rise && w_busy) begin
        r_shift       <= 16'h0000;
        r_bit_cnt     <= 4'd0;
        r_done        <= 1'b0;
        r_frame_error <= 1'b1;
      end else if (w_shift_en) begin
        r_shift       <= {r_shift[14:0], w_sdata_s};
        r_bit_cnt     <= r_bit_cnt + 4'd1;  // wraps to 0 after bit 16
        r_done        <= (r_bit_cnt == 4'd15);
        r_frame_error <= 1'b0;
      end else begin
        r_done        <= 1'b0;
        r_frame_error <= 1'b0;
      end
    end
  end

  // Decode of a completed word into the register shadow.
  always_comb begin
    w_control_nxt  = r_control;
    w_freq0_nxt    = r_freq0;
    w_freq1_nxt    = r_freq1;
    w_phase0_nxt   = r_phase0;
    w_phase1_nxt   = r_phase1;
    w_half_msb_nxt = r_half_msb;
    // With B28 set the shared half-select picks the half; otherwise HLB does.
    w_freq_hi      = r_control[13] ? r_half_msb : r_control[12];
    if (r_done) begin
      case (r_shift[15:14])
        2'b00: begin
          w_control_nxt  = r_shift[13:0];
          w_half_msb_nxt = 1'b0;
        end
        2'b01: begin
          if (w_freq_hi) begin
            w_freq0_nxt = {r_shift[13:0], r_freq0[13:0]};
          end else begin
            w_freq0_nxt = {r_freq0[27:14], r_shift[13:0]};
          end
          if (r_control[13]) begin
            w_half_msb_nxt = ~r_half_msb;
          end else begin
            w_half_msb_nxt = r_half_msb;
          end
        end
        2'b10: begin
          if (w_freq_hi) begin
            w_freq1_nxt = {r_shift[13:0], r_freq1[13:0]};
          end else begin
            w_freq1_nxt = {r_freq1[27:14], r_shift[13:0]};
          end
          if (r_control[13]) begin
            w_half_msb_nxt = ~r_half_msb;
          end else begin
            w_half_msb_nxt = r_half_msb;
          end
        end
        2'b11: begin
          if (r_shift[13]) begin
            w_phase1_nxt = r_shift[11:0];
          end else begin
            w_phase0_nxt = r_shift[11:0];
          end
        end
        default: begin
          w_control_nxt = r_control;
        end
      endcase
    end else begin
      w_half_msb_nxt = r_half_msb;
    end
  end

  // Register the word, its valid pulse and the decoded shadow registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_word       <= 16'h0000;
      r_word_valid <= 1'b0;
      r_control    <= 14'h0000;
      r_freq0      <= 28'h0000000;
      r_freq1      <= 28'h0000000;
      r_phase0     <= 12'h000;
      r_phase1     <= 12'h000;
      r_half_msb   <= 1'b0;
    end else begin
      if (r_done) begin
        r_word <= r_shift;
      end else begin
        r_word <= r_word;
      end
      r_word_valid <= r_done;
      r_control    <= w_control_nxt;
      r_freq0      <= w_freq0_nxt;
      r_freq1      <= w_freq1_nxt;
      r_phase0     <= w_phase0_nxt;
      r_phase1     <= w_phase1_nxt;
      r_half_msb   <= w_half_msb_nxt;
    end
  end

  assign word        = r_word;
  assign word_valid  = r_word_valid;
  assign control     = r_control;
  assign freq0       = r_freq0;
  assign freq1       = r_freq1;
  assign phase0      = r_phase0;
  assign phase1      = r_phase1;
  assign frame_error = r_frame_error;
  assign busy        = w_busy;

endmodule

// File: tb/tb_ad9833_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_ad9833_spi_rx
// Self-checking bench for ad9833_spi_rx: directed frames followed by random
// frames, compared against an arithmetic register model of the AD9833.
// ---------------------------------------------------------------------------
module tb_ad9833_spi_rx;

  localparam int HOLD = 6;  // clocks per sclk phase / fsync setup-hold

  logic        clock;
  logic        resetn;
  logic        fsync;
  logic        sclk;
  logic        sdata;
  logic [15:0] word;
  logic        word_valid;
  logic [13:0] control;
  logic [27:0] freq0;
  logic [27:0] freq1;
  logic [11:0] phase0;
  logic [11:0] phase1;
  logic        frame_error;
  logic        busy;

  ad9833_spi_rx #(.SYNC_STAGES(2)) dut (
    .clock(clock), .resetn(resetn), .fsync(fsync), .sclk(sclk), .sdata(sdata),
    .word(word), .word_valid(word_valid), .control(control),
    .freq0(freq0), .freq1(freq1), .phase0(phase0), .phase1(phase1),
    .frame_error(frame_error), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_ferr  = 0;

  always @(posedge clock) begin
    if (word_valid === 1'b1) n_valid <= n_valid + 1;
    if (frame_error === 1'b1) n_ferr <= n_ferr + 1;
  end

  // Reference model state
  logic [15:0] m_word;
  logic [13:0] m_control;
  logic [27:0] m_freq0, m_freq1;
  logic [11:0] m_phase0, m_phase1;
  bit          m_half_msb;
  int          m_valid, m_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word = 16'h0; m_control = 14'h0; m_freq0 = 28'h0; m_freq1 = 28'h0;
    m_phase0 = 12'h0; m_phase1 = 12'h0; m_half_msb = 1'b0;
  endtask

  function automatic logic [27:0] fwrite(input logic [27:0] f, input logic [13:0] d, input bit hi);
    logic [27:0] r;
    if (hi) r = (f % 28'd16384) + ({14'h0, d} * 28'd16384);
    else    r = f - (f % 28'd16384) + {14'h0, d};
    return r;
  endfunction

  task automatic model_apply(input logic [15:0] w);
    int  kind;
    bit  hi;
    kind = int'(w) / 16384;
    m_word = w;
    m_valid++;
    if (kind == 0) begin
      m_control  = w[13:0];
      m_half_msb = 1'b0;
    end else if (kind == 3) begin
      if (w[13]) m_phase1 = w[11:0];
      else       m_phase0 = w[11:0];
    end else begin
      if (m_control[13]) begin
        hi = m_half_msb;
        m_half_msb = !m_half_msb;
      end else begin
        hi = m_control[12];
      end
      if (kind == 1) m_freq0 = fwrite(m_freq0, w[13:0], hi);
      else           m_freq1 = fwrite(m_freq1, w[13:0], hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send_bits(input logic [15:0] w, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      sdata = w[i];
      wait_clk(HOLD);
      sclk = 1'b0;
      wait_clk(HOLD);
      sclk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [15:0] ws[$]);
    fsync = 1'b0;
    wait_clk(HOLD);
    foreach (ws[k]) send_bits(ws[k], 16);
    wait_clk(HOLD);
    fsync = 1'b1;
    wait_clk(HOLD);
    foreach (ws[k]) model_apply(ws[k]);
  endtask

  task automatic check_all(input string tag);
    @(negedge clock);
    check({tag, ".word"},    {16'h0, word},    {16'h0, m_word});
    check({tag, ".control"}, {18'h0, control}, {18'h0, m_control});
    check({tag, ".freq0"},   {4'h0, freq0},    {4'h0, m_freq0});
    check({tag, ".freq1"},   {4'h0, freq1},    {4'h0, m_freq1});
    check({tag, ".phase0"},  {20'h0, phase0},  {20'h0, m_phase0});
    check({tag, ".phase1"},  {20'h0, phase1},  {20'h0, m_phase1});
    check({tag, ".busy"},    {31'h0, busy},    32'h0);
    check({tag, ".nvalid"},  n_valid,          m_valid);
    check({tag, ".nferr"},   n_ferr,           m_ferr);
  endtask

  logic [15:0] q[$];

  initial begin
    fsync = 1'b1; sclk = 1'b1; sdata = 1'b0; resetn = 1'b0;
    model_reset();
    m_valid = 0; m_ferr = 0;
    wait_clk(3);
    check_all("reset");
    resetn = 1'b1;
    wait_clk(3);

    // Continuous load of three words in one frame
    q = '{16'h2100, 16'h50C7, 16'h4000};
    send_frame(q);
    check_all("tp1");
    check("tp1.control_k", {18'h0, control}, 32'h2100);
    check("tp1.freq0_k",   {4'h0, freq0},    32'h00010C7);

    // B28 LSB/MSB sequencing on FREQ1
    q = '{16'h2000}; send_frame(q);
    q = '{16'h8001}; send_frame(q);
    q = '{16'h8002}; send_frame(q);
    check_all("tp2");
    check("tp2.freq1_k", {4'h0, freq1}, 32'h0008001);

    // HLB selects MSB half
    q = '{16'h1000}; send_frame(q);
    q = '{16'h7FFF}; send_frame(q);
    check_all("tp3");
    check("tp3.freq0_k", {4'h0, freq0}, 32'hFFFC000 | 32'h10C7);

    // Phase writes
    q = '{16'hC555}; send_frame(q);
    q = '{16'hE123}; send_frame(q);
    check_all("tp4");
    check("tp4.phase_k", {8'h0, phase0, phase1}, 32'h00555123);

    // Abort after 9 bits
    fsync = 1'b0;
    wait_clk(HOLD);
    send_bits(16'h8ABC, 9);
    wait_clk(2);
    @(negedge clock);
    check("tp5.busy_mid", {31'h0, busy}, 32'h1);
    fsync = 1'b1;
    wait_clk(HOLD + 4);
    m_ferr++;
    check_all("tp5.abort");
    q = '{16'h0042}; send_frame(q);
    check_all("tp5.next");
    check("tp5.control_k", {18'h0, control}, 32'h0042);

    // Reset mid-frame
    fsync = 1'b0;
    wait_clk(HOLD);
    send_bits(16'h5ABC, 8);
    @(negedge clock);
    check("tp6.busy_pre", {31'h0, busy}, 32'h1);
    resetn = 1'b0;
    #1;
    check("tp6.word0",    {16'h0, word},    32'h0);
    check("tp6.control0", {18'h0, control}, 32'h0);
    check("tp6.freq0",    {4'h0, freq0},    32'h0);
    check("tp6.phase1",   {20'h0, phase1},  32'h0);
    check("tp6.busy0",    {31'h0, busy},    32'h0);
    fsync = 1'b1; sclk = 1'b1;
    model_reset();
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(4);
    q = '{16'h4001}; send_frame(q);
    check_all("tp6.after");
    check("tp6.freq0_k", {4'h0, freq0}, 32'h0000001);

    // Random frames of 1..3 words
    for (int f = 0; f < 20; f++) begin
      q = {};
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) q.push_back(16'($urandom));
      send_frame(q);
      check_all($sformatf("rnd%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
